// File: rtl/ib_seq_pkg.sv
// Shared constants for the instruction-buffer sequencer: FSM state encoding
// and default bus widths.
package ib_seq_pkg;

  localparam int DEF_ADDR_BITS = 10;
  localparam int DEF_INST_BITS = 128;

  localparam int STATE_BITS = 3;

  localparam logic [STATE_BITS-1:0] IDLE      = 3'd0;
  localparam logic [STATE_BITS-1:0] PRIME     = 3'd1;
  localparam logic [STATE_BITS-1:0] PRIME_ACK = 3'd2;
  localparam logic [STATE_BITS-1:0] FETCH     = 3'd3;
  localparam logic [STATE_BITS-1:0] WAIT_ACK  = 3'd4;
  localparam logic [STATE_BITS-1:0] ISSUE     = 3'd5;
  localparam logic [STATE_BITS-1:0] EXEC      = 3'd6;
  localparam logic [STATE_BITS-1:0] DONE      = 3'd7;

endpackage

// File: rtl/ib_seq_window_cnt.sv
// Window length, in-pass index and pass counter for the sequencer, with
// terminal-count flags for the last word of a pass and the last pass.
module ib_seq_window_cnt #(
  parameter int ADDR_BITS = 10,
  parameter int LOOP_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [ADDR_BITS-1:0] end_addr,
  input  logic                 step,
  input  logic [LOOP_BITS-1:0] loops,
  output logic                 last_in_pass,
  output logic                 last_pass,
  output logic [LOOP_BITS-1:0] pass_cnt
);

  localparam logic [ADDR_BITS:0]   IDX_ONE  = 1;
  localparam logic [LOOP_BITS-1:0] PASS_ONE = 1;

  logic [ADDR_BITS:0]   len_q;
  logic [ADDR_BITS:0]   idx_q;
  logic [ADDR_BITS:0]   len_d;
  logic [ADDR_BITS-1:0] span;
  logic [LOOP_BITS-1:0] pass_next;

  // One extra bit so a full 2**ADDR_BITS window length is representable.
  always_comb begin
    span  = (end_addr >= start_addr) ? end_addr - start_addr : start_addr - end_addr;
    len_d = {1'b0, span} + IDX_ONE;
  end

  assign pass_next    = pass_cnt + PASS_ONE;
  assign last_in_pass = (idx_q + IDX_ONE == len_q);
  assign last_pass    = (loops != '0) && (pass_next == loops);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q    <= '0;
      idx_q    <= '0;
      pass_cnt <= '0;
    end else if (load) begin
      len_q    <= len_d;
      idx_q    <= '0;
      pass_cnt <= '0;
    end else if (step) begin
      if (last_in_pass) begin
        idx_q    <= '0;
        pass_cnt <= pass_next;
      end else begin
        idx_q <= idx_q + IDX_ONE;
      end
    end
  end

endmodule

// File: rtl/ib_sequencer.sv
// Instruction-buffer sequencer: primes the buffer, fetches each word of a
// programmed window, hands it to execute and waits for completion.
module ib_sequencer
  import ib_seq_pkg::*;
#(
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int INST_BITS   = DEF_INST_BITS,
  parameter int LOOP_BITS   = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_start,
  input  logic [ADDR_BITS-1:0] cfg_start_addr,
  input  logic [ADDR_BITS-1:0] cfg_end_addr,
  input  logic                 cfg_incr,
  input  logic [LOOP_BITS-1:0] cfg_loops,
  input  logic                 abort,
  output logic                 ib_en,
  output logic                 ib_flag,
  output logic                 ib_jmp,
  output logic                 ib_mode,
  output logic                 ib_incr,
  output logic [ADDR_BITS-1:0] ib_start_addr,
  output logic [ADDR_BITS-1:0] ib_end_addr,
  input  logic [INST_BITS-1:0] ib_instruction,
  input  logic                 ib_init_pulse,
  output logic                 inst_valid,
  output logic [INST_BITS-1:0] inst_data,
  input  logic                 inst_ready,
  input  logic                 exec_done,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [LOOP_BITS-1:0] pass_cnt
);

  localparam int                  TIMER_BITS   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TIMER_BITS-1:0] TIMER_ONE  = 1;
  localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(ACK_TIMEOUT - 1);

  logic [STATE_BITS-1:0] state_q, state_d;
  logic [TIMER_BITS-1:0] timer_q;
  logic start_req, start_bad, start_ok;
  logic in_ack, timeout, step;
  logic last_in_pass, last_pass;

  // The buffer runs in wrap mode permanently; terminations are counted here.
  assign ib_en   = 1'b1;
  assign ib_mode = 1'b1;

  assign start_req = cfg_start && (state_q == IDLE) && !abort;
  assign start_bad = cfg_incr && (cfg_start_addr > cfg_end_addr);
  assign start_ok  = start_req && !start_bad;
  assign in_ack    = (state_q == PRIME_ACK) || (state_q == WAIT_ACK);
  assign timeout   = in_ack && !ib_init_pulse && (timer_q == TIMER_LAST);
  assign step      = (state_q == EXEC) && exec_done && !abort;

  // Strobes decode straight from the state register, so each flag lasts one
  // cycle and the ack-wait state that follows always drives it low.
  assign ib_flag    = (state_q == PRIME) || (state_q == FETCH);
  assign ib_jmp     = (state_q == PRIME);
  assign inst_valid = (state_q == ISSUE);
  assign done       = (state_q == DONE);
  assign busy       = (state_q != IDLE);

  ib_seq_window_cnt #(
    .ADDR_BITS (ADDR_BITS),
    .LOOP_BITS (LOOP_BITS)
  ) u_window_cnt (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (start_ok),
    .start_addr   (cfg_start_addr),
    .end_addr     (cfg_end_addr),
    .step         (step),
    .loops        (cfg_loops),
    .last_in_pass (last_in_pass),
    .last_pass    (last_pass),
    .pass_cnt     (pass_cnt)
  );

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_ok) state_d = PRIME;
      PRIME:     state_d = PRIME_ACK;
      PRIME_ACK: if (ib_init_pulse) state_d = FETCH;
                 else if (timeout) state_d = IDLE;
      FETCH:     state_d = WAIT_ACK;
      WAIT_ACK:  if (ib_init_pulse) state_d = ISSUE;
                 else if (timeout) state_d = IDLE;
      ISSUE:     if (inst_ready) state_d = EXEC;
      EXEC:      if (exec_done) state_d = (last_in_pass && last_pass) ? DONE : FETCH;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      err           <= 1'b0;
      ib_incr       <= 1'b0;
      ib_start_addr <= '0;
      ib_end_addr   <= '0;
      inst_data     <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= in_ack ? timer_q + TIMER_ONE : '0;
      if (start_ok) begin
        ib_incr       <= cfg_incr;
        ib_start_addr <= cfg_start_addr;
        ib_end_addr   <= cfg_end_addr;
        err           <= 1'b0;
      end else if (start_req && start_bad) begin
        err <= 1'b1;
      end else if (timeout && !abort) begin
        err <= 1'b1;
      end
      if ((state_q == WAIT_ACK) && ib_init_pulse) inst_data <= ib_instruction;
    end
  end

endmodule

// File: tb/tb_ib_sequencer.sv
// Self-checking bench for ib_sequencer: behavioural instruction buffer and
// execute stage, with expected fetch sequences computed from window rules.
module tb_ib_sequencer;

  localparam int AB = 10;
  localparam int IB = 128;
  localparam int LB = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cfg_start, cfg_incr, abort;
  logic [AB-1:0] cfg_start_addr, cfg_end_addr;
  logic [LB-1:0] cfg_loops;
  logic          ib_en, ib_flag, ib_jmp, ib_mode, ib_incr;
  logic [AB-1:0] ib_start_addr, ib_end_addr;
  logic [IB-1:0] ib_instruction;
  logic          ib_init_pulse;
  logic          inst_valid, inst_ready, exec_done;
  logic [IB-1:0] inst_data;
  logic          busy, done, err;
  logic [LB-1:0] pass_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [IB-1:0] mem [16];

  // monitor counters
  int flag_total = 0, prime_total = 0, done_total = 0, b2b_bad = 0, jmp_bad = 0;
  logic prev_flag = 1'b0;

  // buffer model state
  bit            ack_enable = 1'b1;
  logic [AB-1:0] ptr = '0;
  bit            pend = 1'b0;
  logic [IB-1:0] pend_data = '0;

  // execute model state
  logic [IB-1:0] got [$];
  int            stall_at = -1;
  int            stall_bad = 0;
  logic [IB-1:0] exec_hold;

  always #5 clk = ~clk;

  ib_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_start      (cfg_start),
    .cfg_start_addr (cfg_start_addr),
    .cfg_end_addr   (cfg_end_addr),
    .cfg_incr       (cfg_incr),
    .cfg_loops      (cfg_loops),
    .abort          (abort),
    .ib_en          (ib_en),
    .ib_flag        (ib_flag),
    .ib_jmp         (ib_jmp),
    .ib_mode        (ib_mode),
    .ib_incr        (ib_incr),
    .ib_start_addr  (ib_start_addr),
    .ib_end_addr    (ib_end_addr),
    .ib_instruction (ib_instruction),
    .ib_init_pulse  (ib_init_pulse),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_ready     (inst_ready),
    .exec_done      (exec_done),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .pass_cnt       (pass_cnt)
  );

  task automatic check(input string tag, input logic [IB-1:0] obs, input logic [IB-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: flag/jmp/done activity sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (ib_flag) begin
      flag_total++;
      if (ib_jmp) prime_total++;
      if (prev_flag) b2b_bad++;
    end
    if (ib_jmp && !ib_flag) jmp_bad++;
    if (done) done_total++;
    prev_flag = ib_flag;
  end

  // Instruction buffer: acks each flag one cycle later; wraps inside the window.
  initial begin
    ib_init_pulse  = 1'b0;
    ib_instruction = '0;
    forever begin
      @(posedge clk); #1;
      ib_init_pulse  = pend;
      ib_instruction = pend ? pend_data : {$urandom, $urandom, $urandom, $urandom};
      pend = 1'b0;
      if (ib_flag) begin
        if (ib_jmp) begin
          ptr       = ib_incr ? ib_start_addr : ib_end_addr;
          pend      = 1'b1;
          pend_data = {$urandom, $urandom, $urandom, $urandom};
        end else if (ack_enable) begin
          pend      = 1'b1;
          pend_data = mem[ptr[3:0]];
          if (ib_incr) ptr = (ptr == ib_end_addr) ? ib_start_addr : ptr + 1'b1;
          else         ptr = (ptr == ib_start_addr) ? ib_end_addr : ptr - 1'b1;
        end
      end
    end
  end

  // Execute stage: accepts, optionally after a 10-cycle stall, then signals
  // completion two cycles after the handshake.
  initial begin
    inst_ready = 1'b0;
    exec_done  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (inst_valid) begin
        exec_hold = inst_data;
        if (got.size() == stall_at) begin
          for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!inst_valid || inst_data !== exec_hold || ib_flag) stall_bad++;
          end
        end
        inst_ready = 1'b1;
        got.push_back(inst_data);
        @(posedge clk); #1;
        inst_ready = 1'b0;
        @(posedge clk); #1;
        exec_done = 1'b1;
        @(posedge clk); #1;
        exec_done = 1'b0;
      end
    end
  end

  task automatic start_job(input int s, input int e, input bit inc, input int loops);
    @(negedge clk);
    cfg_start_addr = AB'(s);
    cfg_end_addr   = AB'(e);
    cfg_incr       = inc;
    cfg_loops      = LB'(loops);
    cfg_start      = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int c = 0; c < budget && busy; c++) @(negedge clk);
    check({tag, " reaches idle"}, busy, 0);
  endtask

  // Reference: a pass visits the window start..end (or end..start), loops times.
  task automatic run_job(input string tag, input int s, input int e, input bit inc,
                         input int loops, input bit poke);
    logic [IB-1:0] exp_q [$];
    int len, g0, f0, p0, d0;
    len = (e >= s) ? e - s + 1 : s - e + 1;
    for (int p = 0; p < loops; p++)
      for (int i = 0; i < len; i++) exp_q.push_back(mem[inc ? s + i : e - i]);
    g0 = got.size(); f0 = flag_total; p0 = prime_total; d0 = done_total;
    start_job(s, e, inc, loops);
    if (poke) begin
      repeat (3) @(negedge clk);
      cfg_start_addr = 10'd9; cfg_end_addr = 10'd1; cfg_incr = 1'b0; cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      check({tag, " start ignored while busy"}, ib_start_addr, s);
    end
    wait_idle(tag, 4000);
    repeat (2) @(negedge clk);
    check({tag, " issue count"}, got.size() - g0, exp_q.size());
    for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++)
      check($sformatf("%s word %0d", tag, i), got[g0 + i], exp_q[i]);
    check({tag, " flag count"}, flag_total - f0, loops * len + 1);
    check({tag, " prime count"}, prime_total - p0, 1);
    check({tag, " done pulses"}, done_total - d0, 1);
    check({tag, " pass_cnt"}, pass_cnt, loops);
    check({tag, " err"}, err, 0);
  endtask

  initial begin
    int g0, f0, d0, c;
    reset_n = 1'b0; cfg_start = 1'b0; cfg_incr = 1'b0; abort = 1'b0;
    cfg_start_addr = '0; cfg_end_addr = '0; cfg_loops = '0;
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};

    #12;
    check("reset ib_en", ib_en, 1);
    check("reset ib_mode", ib_mode, 1);
    check("reset busy", busy, 0);
    check("reset flag", ib_flag, 0);
    check("reset inst_valid", inst_valid, 0);
    check("reset pass_cnt", pass_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post-reset err", err, 0);
    check("post-reset done", done, 0);

    run_job("w0-3 incr", 0, 3, 1'b1, 1, 1'b0);
    run_job("w5-7 decr", 5, 7, 1'b0, 2, 1'b0);

    // stall: the second issue of this job is held off for 10 cycles
    stall_at = got.size() + 1;
    run_job("stall", 4, 6, 1'b1, 1, 1'b1);
    check("stall stable", stall_bad, 0);

    for (int r = 0; r < 3; r++) begin
      int s, e;
      s = $urandom_range(0, 15);
      e = $urandom_range(s, 15);
      run_job($sformatf("rand%0d", r), s, e, bit'($urandom_range(0, 1)), $urandom_range(1, 3), 1'b0);
    end

    // endless single-word loop, aborted after five completed passes
    g0 = got.size(); d0 = done_total;
    start_job(2, 2, 1'b1, 0);
    for (c = 0; c < 2000 && pass_cnt != 5; c++) @(negedge clk);
    check("loop pass_cnt reached", pass_cnt, 5);
    check("loop issues", got.size() - g0, 5);
    for (int i = 0; i < 5 && g0 + i < got.size(); i++)
      check($sformatf("loop word %0d", i), got[g0 + i], mem[2]);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort flag", ib_flag, 0);
    check("abort inst_valid", inst_valid, 0);
    repeat (3) @(negedge clk);
    check("abort pass_cnt kept", pass_cnt, 5);
    check("abort no done", done_total - d0, 0);

    // rejected start: ascending window with start > end
    f0 = flag_total;
    start_job(6, 3, 1'b1, 1);
    check("reject err", err, 1);
    check("reject busy", busy, 0);
    repeat (2) @(negedge clk);
    check("reject no flag", flag_total - f0, 0);

    // acknowledge timeout on the first fetch
    ack_enable = 1'b0;
    d0 = done_total;
    start_job(0, 3, 1'b1, 1);
    for (c = 0; c < 20 && !(ib_flag && !ib_jmp); c++) @(negedge clk);
    check("timeout fetch seen", ib_flag && !ib_jmp, 1);
    repeat (4) @(negedge clk);
    check("timeout busy before", busy, 1);
    check("timeout err before", err, 0);
    @(negedge clk);
    check("timeout err", err, 1);
    check("timeout idle", busy, 0);
    check("timeout no done", done_total - d0, 0);
    ack_enable = 1'b1;
    run_job("after timeout", 1, 2, 1'b1, 1, 1'b0);

    // asynchronous reset in the middle of a run
    start_job(0, 7, 1'b1, 3);
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async reset busy", busy, 0);
    check("async reset inst_data", inst_data, 0);
    check("async reset ib_start_addr", ib_start_addr, 0);
    check("async reset ib_en", ib_en, 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("async reset stays idle", busy, 0);

    check("no back-to-back flags", b2b_bad, 0);
    check("jmp only with prime flag", jmp_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ib_sequencer.md
Name: ib_sequencer

Overview:
- Controller that drives the instruction buffer's control interface: flag pulses, jump, mode, direction, address window.
- Runs a programmed address window for N passes, or forever. Each fetched instruction goes to the execute stage over a valid/ready handshake.
- Waits for execute completion before fetching the next instruction.
- Sits between the host configuration registers, the instruction buffer and the systolic-array execute control.

Parameters:
- ADDR_BITS, 10, instruction buffer address width.
- INST_BITS, 128, instruction word width.
- LOOP_BITS, 16, width of the pass counter.
- ACK_TIMEOUT, 4, cycles allowed between a flag pulse and ib_init_pulse before an error is raised.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous assert, active-low.
- cfg_start  in  1  one-cycle start request; ignored while busy.
- cfg_start_addr  in  ADDR_BITS  window start address; latched on accepted start.
- cfg_end_addr  in  ADDR_BITS  window end address; latched on accepted start.
- cfg_incr  in  1  1 = ascending fetch, 0 = descending fetch; latched on accepted start.
- cfg_loops  in  LOOP_BITS  number of passes; 0 = run until abort.
- abort  in  1  stop request, sampled every cycle.
- ib_en  out  1  instruction buffer enable.
- ib_flag  out  1  fetch strobe to the instruction buffer.
- ib_jmp  out  1  jump request to the instruction buffer.
- ib_mode  out  1  instruction buffer mode.
- ib_incr  out  1  instruction buffer direction.
- ib_start_addr  out  ADDR_BITS  window start to the instruction buffer.
- ib_end_addr  out  ADDR_BITS  window end to the instruction buffer.
- ib_instruction  in  INST_BITS  instruction read data.
- ib_init_pulse  in  1  fetch acknowledge; read data is valid in this cycle.
- inst_valid  out  1  instruction offered to execute.
- inst_data  out  INST_BITS  captured instruction.
- inst_ready  in  1  execute accepts the instruction.
- exec_done  in  1  one-cycle pulse: the issued instruction has finished.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  sticky acknowledge-timeout flag; cleared only by reset or an accepted cfg_start.
- pass_cnt  out  LOOP_BITS  number of completed passes.

Behaviour:
- Reset values: all outputs 0 except ib_en=1 and ib_mode=1. State = IDLE.
- ib_en is held 1 at all times after reset.
- ib_mode is constant 1 (wrap mode); pass and window termination are counted locally.
- On accepted cfg_start (IDLE only):
  - latch window and direction;
  - compute len = |end-start|+1 at ADDR_BITS+1 width; start==end gives len=1;
  - clear pass_cnt and err.
- If cfg_incr=1 and start>end, the request is rejected: err set, no state change.
- ib_flag is high for exactly one cycle per request and is always low in the following cycle (the buffer edge-detects it).
- ib_jmp is high only in the same cycle as a PRIME flag.
- States:
  - IDLE: wait for cfg_start.
  - PRIME: flag=1, jmp=1. Positions the buffer counter at start (incr) or end (decr). The read data is discarded. Go to PRIME_ACK.
  - PRIME_ACK: wait for ib_init_pulse, then go to FETCH.
  - FETCH: flag=1, jmp=0. Go to WAIT_ACK.
  - WAIT_ACK: on ib_init_pulse, capture ib_instruction into inst_data and go to ISSUE.
  - ISSUE: inst_valid=1 with inst_data held stable. On inst_ready, go to EXEC.
  - EXEC: on exec_done, increment the in-pass index.
    - If index < len: go to FETCH.
    - Else (end of pass): pass_cnt++ and index cleared. If cfg_loops≠0 and pass_cnt==cfg_loops, go to DONE; otherwise go to FETCH (the buffer wraps by itself).
  - DONE: done=1 for one cycle, then IDLE.
- Acknowledge timeout: if no ib_init_pulse arrives within ACK_TIMEOUT cycles in PRIME_ACK or WAIT_ACK, set err and go to IDLE without a done pulse.
- Throughput: fetch-to-issue latency is 2 cycles (FETCH → ack → ISSUE). The minimum per-instruction loop is 4 cycles plus execute time.
- abort has priority over every transition. The next state is IDLE; inst_valid, ib_flag and ib_jmp drop the following cycle; no done pulse; pass_cnt is retained.
- exec_done outside EXEC and ib_init_pulse outside the ack states are ignored.
- An asynchronous reset mid-operation returns to IDLE immediately with all reset values applied.

Decomposition:
- Shared package ib_seq_pkg holds:
  - state encoding localparams: IDLE, PRIME, PRIME_ACK, FETCH, WAIT_ACK, ISSUE, EXEC, DONE;
  - the default ADDR_BITS and INST_BITS constants.
- One natural sub-module: ib_seq_window_cnt, holding the len computation plus the index and pass counters with terminal-count outputs. The FSM stays in the top level.

Test Plan:
- Window 0..3, incr, loops=1, with exec_done 2 cycles after each issue:
  - one PRIME (with jmp) followed by exactly 4 FETCH flags;
  - inst_data equals memory words 0,1,2,3 in order;
  - done pulses once and pass_cnt=1.
- Window 5..7, decr, loops=2:
  - inst_data sequence is 7,6,5,7,6,5;
  - pass_cnt=2 and done pulses once.
- loops=0, window 2..2: a single-word loop repeats; abort after the 5th issue → IDLE next cycle, no done, pass_cnt=5.
- inst_ready held low 10 cycles in ISSUE: inst_valid and inst_data stay stable and no flag pulses occur during the stall.
- ib_init_pulse suppressed after a FETCH: err=1 after 4 cycles, IDLE, busy=0; a new cfg_start clears err.
- cfg_start repeated while busy: ignored. Check ib_flag never high on two consecutive cycles across all runs.
